// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source for the pixel pipeline.
// Emits registered vsync/hsync/valid/data from stream or test patterns.
//
// Parameters
//   DW                 pixel width (>= 3)
//   H_SYNC/H_BACK/H_DISP/H_FRONT  horizontal timing in clocks
//   V_SYNC/V_BACK/V_DISP/V_FRONT  vertical timing in lines
//   CNT_W              h/v counter width
//
// Ports
//   clk, rst_n         pixel clock, synchronous active-low reset
//   en                 run request (stop takes effect at frame end)
//   mode               0 stream, 1 colour bar, 2 gradient, 3 solid
//   solid_val          solid-mode pixel value
//   src_valid/src_data upstream pixel stream
//   src_ready          upstream pixel consumed this cycle
//   img_vsync/img_hsync/img_valid/img_data  pixel bus
//   frame_start        pulse on first output cycle of a frame
//   underflow          sticky: stream pixel missing when needed
//   frame_cnt          frames started, wraps
module video_timing_gen #(
   parameter int DW      = 8,
   parameter int H_SYNC  = 40,
   parameter int H_BACK  = 220,
   parameter int H_DISP  = 1280,
   parameter int H_FRONT = 110,
   parameter int V_SYNC  = 5,
   parameter int V_BACK  = 20,
   parameter int V_DISP  = 720,
   parameter int V_FRONT = 5,
   parameter int CNT_W   = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] solid_val,
   input  logic          src_valid,
   input  logic [DW-1:0] src_data,
   output logic          src_ready,
   output logic          img_vsync,
   output logic          img_hsync,
   output logic          img_valid,
   output logic [DW-1:0] img_data,
   output logic          frame_start,
   output logic          underflow,
   output logic [15:0]   frame_cnt
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int H_ACT_S = H_SYNC + H_BACK;
   localparam int H_ACT_E = H_ACT_S + H_DISP;
   localparam int V_ACT_S = V_SYNC + V_BACK;
   localparam int V_ACT_E = V_ACT_S + V_DISP;
   localparam int BAR_W   = H_DISP / 8;

   localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_H_SYNC  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] C_V_SYNC  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] C_H_ACT_S = CNT_W'(H_ACT_S);
   localparam logic [CNT_W-1:0] C_H_ACT_E = CNT_W'(H_ACT_E);
   localparam logic [CNT_W-1:0] C_V_ACT_S = CNT_W'(V_ACT_S);
   localparam logic [CNT_W-1:0] C_V_ACT_E = CNT_W'(V_ACT_E);
   localparam logic [CNT_W-1:0] C_BAR_LST = CNT_W'(BAR_W - 1);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_h;
   logic [CNT_W-1:0] r_v;
   logic [1:0]       r_mode_q;
   logic [DW-1:0]    r_solid_q;
   logic [CNT_W-1:0] r_bar_pos;
   logic [2:0]       r_bar;
   logic             r_vsync;
   logic             r_hsync;
   logic             r_valid;
   logic [DW-1:0]    r_data;
   logic             r_fstart;
   logic             r_uflow;
   logic [15:0]      r_fcnt;

   logic             w_run;
   logic             w_h_last;
   logic             w_v_last;
   logic             w_frame_end;
   logic             w_origin;
   logic             w_hs;
   logic             w_vs;
   logic             w_h_act;
   logic             w_v_act;
   logic             w_active;
   logic             w_stream;
   logic [CNT_W-1:0] w_x;
   logic [DW-1:0]    w_pix;

   assign w_run       = (r_state != ST_IDLE);
   assign w_h_last    = (r_h == C_H_LAST);
   assign w_v_last    = (r_v == C_V_LAST);
   assign w_frame_end = w_h_last & w_v_last;
   assign w_origin    = (r_h == '0) & (r_v == '0);

   assign w_hs    = (r_h < C_H_SYNC);
   assign w_vs    = (r_v < C_V_SYNC);
   assign w_h_act = (r_h >= C_H_ACT_S) & (r_h < C_H_ACT_E);
   assign w_v_act = (r_v >= C_V_ACT_S) & (r_v < C_V_ACT_E);
   assign w_active = w_h_act & w_v_act;

   // Column within the active area; only meaningful while w_h_act.
   assign w_x = r_h - C_H_ACT_S;

   // The source never stalls timing: ready follows the raster only.
   assign w_stream  = w_run & w_active & (r_mode_q == 2'd0);
   assign src_ready = w_stream;

   always_comb begin
      w_pix = '0;
      unique case (r_mode_q)
         2'd0:    w_pix = src_valid ? src_data : '0;
         2'd1:    w_pix = DW'(r_bar) << (DW - 3);
         2'd2:    w_pix = DW'(w_x);
         default: w_pix = r_solid_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_h       <= '0;
         r_v       <= '0;
         r_mode_q  <= '0;
         r_solid_q <= '0;
         r_bar_pos <= '0;
         r_bar     <= '0;
         r_vsync   <= 1'b0;
         r_hsync   <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_fstart  <= 1'b0;
         r_uflow   <= 1'b0;
         r_fcnt    <= '0;
      end else begin
         // A stop request seen on the last position ends the frame
         // right there; otherwise DRAIN carries it to its end.
         unique case (r_state)
            ST_IDLE: begin
               if (en)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!en)
                  r_state <= w_frame_end ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (en)
                  r_state <= ST_RUN;
               else if (w_frame_end)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_run) begin
            if (w_h_last) begin
               r_h <= '0;
               r_v <= w_v_last ? '0 : r_v + C_ONE;
            end else begin
               r_h <= r_h + C_ONE;
            end
         end else begin
            r_h <= '0;
            r_v <= '0;
         end

         if (w_run && w_origin) begin
            r_mode_q  <= mode;
            r_solid_q <= solid_val;
         end

         // Bar index tracks x/BAR_W without a divider.
         if (w_run && w_h_act) begin
            if (r_bar_pos == C_BAR_LST) begin
               r_bar_pos <= '0;
               r_bar     <= r_bar + 3'd1;
            end else begin
               r_bar_pos <= r_bar_pos + C_ONE;
            end
         end else begin
            r_bar_pos <= '0;
            r_bar     <= '0;
         end

         r_hsync  <= w_run & w_hs;
         r_vsync  <= w_run & w_vs;
         r_valid  <= w_run & w_active;
         r_data   <= (w_run & w_active) ? w_pix : '0;
         r_fstart <= w_run & w_origin;

         if (w_run && w_origin)
            r_fcnt <= r_fcnt + 16'd1;

         if (w_stream && !src_valid)
            r_uflow <= 1'b1;
      end
   end

   assign img_vsync   = r_vsync;
   assign img_hsync   = r_hsync;
   assign img_valid   = r_valid;
   assign img_data    = r_data;
   assign frame_start = r_fstart;
   assign underflow   = r_uflow;
   assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen.
// Small raster: H 2/3/8/2 (15 clocks), V 1/2/4/1 (8 lines).
module tb_video_timing_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [7:0] solid_val;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_ready;
   logic       img_vsync;
   logic       img_hsync;
   logic       img_valid;
   logic [7:0] img_data;
   logic       frame_start;
   logic       underflow;
   logic [15:0] frame_cnt;

   int n_checks;
   int n_errors;
   logic [15:0] exp_fc;

   video_timing_gen #(
      .DW(8), .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
      .solid_val(solid_val), .src_valid(src_valid),
      .src_data(src_data), .src_ready(src_ready),
      .img_vsync(img_vsync), .img_hsync(img_hsync),
      .img_valid(img_valid), .img_data(img_data),
      .frame_start(frame_start), .underflow(underflow),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raster position k counted from the first cycle at (0,0).
   function automatic int ph(input int k);
      return k % 15;
   endfunction
   function automatic int pv(input int k);
      return (k / 15) % 8;
   endfunction
   function automatic logic pact(input int k);
      return (ph(k) >= 5 && ph(k) < 13 && pv(k) >= 3 && pv(k) < 7);
   endfunction

   // From IDLE: after this the counters hold (0,0) in RUN.
   task automatic start_run();
      en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({img_vsync, img_hsync, img_valid, frame_start, underflow,
           src_ready} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_flags got %b exp 000000",
            {img_vsync, img_hsync, img_valid, frame_start, underflow,
             src_ready});
      end
      n_checks++;
      if (img_data !== 8'h00 || frame_cnt !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_data data=%h cnt=%h exp 00/0000",
            img_data, frame_cnt);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (img_hsync !== 1'b0 || img_vsync !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_sync hs=%b vs=%b exp 0/0",
            img_hsync, img_vsync);
      end
      exp_fc = 16'h0;
   endtask

   task automatic test_gradient();
      int nv;
      logic [7:0] ed;
      nv = 0;
      mode = 2'd2;
      start_run();
      for (int k = 0; k < 240; k++) begin
         if (k == 170) en = 1'b0;
         n_checks++;
         if (src_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL grad_ready k=%0d got %b exp 0", k, src_ready);
         end
         @(negedge clk);
         ed = pact(k) ? 8'(ph(k) - 5) : 8'h00;
         n_checks++;
         if (img_hsync !== (ph(k) < 2)) begin
            n_errors++;
            $display("FAIL grad_hsync k=%0d got %b", k, img_hsync);
         end
         n_checks++;
         if (img_vsync !== ((k % 120) < 15)) begin
            n_errors++;
            $display("FAIL grad_vsync k=%0d got %b", k, img_vsync);
         end
         n_checks++;
         if (img_valid !== pact(k)) begin
            n_errors++;
            $display("FAIL grad_valid k=%0d got %b exp %b",
               k, img_valid, pact(k));
         end
         n_checks++;
         if (img_data !== ed) begin
            n_errors++;
            $display("FAIL grad_data k=%0d got %h exp %h",
               k, img_data, ed);
         end
         n_checks++;
         if (frame_start !== ((k % 120) == 0)) begin
            n_errors++;
            $display("FAIL grad_fstart k=%0d got %b", k, frame_start);
         end
         if (img_valid) nv++;
         if ((k % 120) == 0) begin
            exp_fc = exp_fc + 16'd1;
            n_checks++;
            if (frame_cnt !== exp_fc) begin
               n_errors++;
               $display("FAIL grad_fcnt k=%0d got %0d exp %0d",
                  k, frame_cnt, exp_fc);
            end
         end
         if ((k % 120) == 119) begin
            n_checks++;
            if (nv != 32) begin
               n_errors++;
               $display("FAIL grad_nvalid got %0d exp 32", nv);
            end
            nv = 0;
         end
      end
   endtask

   task automatic test_stream();
      logic [7:0] nxt;
      logic [7:0] ed;
      int hs;
      nxt = 8'h10;
      hs = 0;
      mode = 2'd0;
      src_valid = 1'b1;
      start_run();
      for (int k = 0; k < 120; k++) begin
         if (k == 50) en = 1'b0;
         src_data = nxt;
         n_checks++;
         if (src_ready !== pact(k)) begin
            n_errors++;
            $display("FAIL strm_ready k=%0d got %b exp %b",
               k, src_ready, pact(k));
         end
         if (src_ready && src_valid) hs++;
         ed = pact(k) ? nxt : 8'h00;
         if (pact(k)) nxt = nxt + 8'd1;
         @(negedge clk);
         n_checks++;
         if (img_data !== ed || img_valid !== pact(k)) begin
            n_errors++;
            $display("FAIL strm_data k=%0d got %h/%b exp %h/%b",
               k, img_data, img_valid, ed, pact(k));
         end
         if (k == 0) begin
            exp_fc = exp_fc + 16'd1;
            n_checks++;
            if (frame_start !== 1'b1 || frame_cnt !== exp_fc) begin
               n_errors++;
               $display("FAIL strm_fstart got %b/%0d exp 1/%0d",
                  frame_start, frame_cnt, exp_fc);
            end
         end
      end
      n_checks++;
      if (hs != 32) begin
         n_errors++;
         $display("FAIL strm_handshakes got %0d exp 32", hs);
      end
      n_checks++;
      if (underflow !== 1'b0) begin
         n_errors++;
         $display("FAIL strm_underflow got %b exp 0", underflow);
      end
   endtask

   task automatic test_starve();
      logic [7:0] nxt;
      logic [7:0] ed;
      nxt = 8'h40;
      mode = 2'd0;
      start_run();
      for (int k = 0; k < 120; k++) begin
         if (k == 70) en = 1'b0;
         src_valid = (k != 67);
         src_data = nxt;
         ed = 8'h00;
         if (pact(k) && k != 67) begin
            ed = nxt;
            nxt = nxt + 8'd1;
         end
         @(negedge clk);
         n_checks++;
         if (img_data !== ed) begin
            n_errors++;
            $display("FAIL starve_data k=%0d got %h exp %h",
               k, img_data, ed);
         end
         n_checks++;
         if (underflow !== (k >= 67)) begin
            n_errors++;
            $display("FAIL starve_uflow k=%0d got %b exp %b",
               k, underflow, (k >= 67));
         end
      end
      exp_fc = exp_fc + 16'd1;
      src_valid = 1'b1;
   endtask

   task automatic test_mode_switch();
      logic [7:0] ed;
      mode = 2'd3;
      solid_val = 8'hA5;
      src_valid = 1'b0;
      start_run();
      for (int k = 0; k < 240; k++) begin
         if (k == 30) begin
            mode = 2'd1;
            solid_val = 8'h5A;
         end
         if (k == 170) en = 1'b0;
         n_checks++;
         if (src_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL msw_ready k=%0d got %b exp 0", k, src_ready);
         end
         @(negedge clk);
         if (!pact(k)) ed = 8'h00;
         else if (k < 120) ed = 8'hA5;
         else ed = 8'((ph(k) - 5) * 32);
         n_checks++;
         if (img_data !== ed || img_valid !== pact(k)) begin
            n_errors++;
            $display("FAIL msw_data k=%0d got %h/%b exp %h/%b",
               k, img_data, img_valid, ed, pact(k));
         end
         if ((k % 120) == 0) begin
            exp_fc = exp_fc + 16'd1;
            n_checks++;
            if (frame_start !== 1'b1 || frame_cnt !== exp_fc) begin
               n_errors++;
               $display("FAIL msw_fstart k=%0d got %b/%0d exp 1/%0d",
                  k, frame_start, frame_cnt, exp_fc);
            end
         end
      end
      n_checks++;
      if (underflow !== 1'b1) begin
         n_errors++;
         $display("FAIL msw_uflow_sticky got %b exp 1", underflow);
      end
   endtask

   task automatic test_stop_restart();
      int nv;
      mode = 2'd2;
      nv = 0;
      start_run();
      for (int k = 0; k < 120; k++) begin
         if (k == 50) en = 1'b0;
         @(negedge clk);
         if (img_valid) nv++;
      end
      exp_fc = exp_fc + 16'd1;
      n_checks++;
      if (nv != 32) begin
         n_errors++;
         $display("FAIL stop_nvalid got %0d exp 32", nv);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if ({img_vsync, img_hsync, img_valid, frame_start, src_ready}
             !== 5'b0 || img_data !== 8'h00) begin
            n_errors++;
            $display("FAIL stop_idle i=%0d got %b/%h exp 00000/00", i,
               {img_vsync, img_hsync, img_valid, frame_start,
                src_ready}, img_data);
         end
      end
      // Restart with en dropped while at (0,0): full frame still runs.
      start_run();
      en = 1'b0;
      nv = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (img_valid) nv++;
         if (k == 0) begin
            exp_fc = exp_fc + 16'd1;
            n_checks++;
            if (frame_start !== 1'b1 || img_hsync !== 1'b1 ||
                frame_cnt !== exp_fc) begin
               n_errors++;
               $display("FAIL restart_first got fs=%b hs=%b cnt=%0d exp 1/1/%0d",
                  frame_start, img_hsync, frame_cnt, exp_fc);
            end
         end
      end
      n_checks++;
      if (nv != 32) begin
         n_errors++;
         $display("FAIL restart_nvalid got %0d exp 32", nv);
      end
      @(negedge clk);
      n_checks++;
      if (img_hsync !== 1'b0 || frame_start !== 1'b0) begin
         n_errors++;
         $display("FAIL restart_idle hs=%b fs=%b exp 0/0",
            img_hsync, frame_start);
      end
      // Brief stop inside a frame: no gap, next frame follows directly.
      start_run();
      for (int k = 0; k < 240; k++) begin
         if (k == 20) en = 1'b0;
         if (k == 25) en = 1'b1;
         if (k == 170) en = 1'b0;
         @(negedge clk);
         n_checks++;
         if (frame_start !== ((k % 120) == 0) ||
             img_valid !== pact(k)) begin
            n_errors++;
            $display("FAIL drain_rerun k=%0d got fs=%b v=%b exp %b/%b",
               k, frame_start, img_valid, ((k % 120) == 0), pact(k));
         end
         if ((k % 120) == 0) exp_fc = exp_fc + 16'd1;
      end
      n_checks++;
      if (frame_cnt !== exp_fc) begin
         n_errors++;
         $display("FAIL drain_fcnt got %0d exp %0d", frame_cnt, exp_fc);
      end
   endtask

   task automatic test_reset_mid();
      mode = 2'd2;
      start_run();
      repeat (51) @(negedge clk);
      n_checks++;
      if (img_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_pre valid got %b exp 1", img_valid);
      end
      rst_n = 1'b0;
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_fc = 16'h0;
      n_checks++;
      if ({img_vsync, img_hsync, img_valid, frame_start, underflow,
           src_ready} !== 6'b0 || img_data !== 8'h00) begin
         n_errors++;
         $display("FAIL rstmid_out got %b/%h exp 000000/00",
            {img_vsync, img_hsync, img_valid, frame_start, underflow,
             src_ready}, img_data);
      end
      n_checks++;
      if (frame_cnt !== 16'h0) begin
         n_errors++;
         $display("FAIL rstmid_fcnt got %0d exp 0", frame_cnt);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (img_hsync !== 1'b0 || img_vsync !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_idle hs=%b vs=%b exp 0/0",
            img_hsync, img_vsync);
      end
      start_run();
      en = 1'b0;
      @(negedge clk);
      exp_fc = exp_fc + 16'd1;
      n_checks++;
      if (frame_start !== 1'b1 || img_vsync !== 1'b1 ||
          frame_cnt !== exp_fc) begin
         n_errors++;
         $display("FAIL rstmid_restart got fs=%b vs=%b cnt=%0d exp 1/1/1",
            frame_start, img_vsync, frame_cnt);
      end
      repeat (125) @(negedge clk);
      n_checks++;
      if (img_hsync !== 1'b0 || img_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid_end hs=%b v=%b exp 0/0",
            img_hsync, img_valid);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_fc = 16'h0;
      rst_n = 1'b0;
      en = 1'b0;
      mode = 2'd0;
      solid_val = 8'h00;
      src_valid = 1'b0;
      src_data = 8'h00;
      test_reset();
      test_gradient();
      test_stream();
      test_starve();
      test_mode_switch();
      test_stop_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors",
         n_checks, n_errors);
      $finish;
   end

endmodule
